pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/pc_redirect_mux.sv | 30 +++
 rtl/pc_sequencer.sv | 109 ++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-address sequencer.
// Holds the FSM state encoding and the default reset/exception vectors.
package pc_seq_pkg;

    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] DEF_EXC_VECTOR   = 32'h8000_0180;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the fetch sequencer, the hazard/redirect logic and the instruction memory.
// master = sequencer side, slave = pipeline/memory environment side.
interface pc_sequencer_if;
    import pc_seq_pkg::*;

    logic              stall;
    logic              exc_req;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              imem_ready;
    logic              imem_req;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              if_valid;
    logic              flush;

    modport master (
        input  stall, exc_req, branch_taken, branch_target, jump, jump_target, imem_ready,
        output imem_req, pc, pc_plus4, if_valid, flush
    );

    modport slave (
        output stall, exc_req, branch_taken, branch_target, jump, jump_target, imem_ready,
        input  imem_req, pc, pc_plus4, if_valid, flush
    );

endinterface

// File: rtl/pc_redirect_mux.sv
// Priority select of the redirect source: exception, then branch, then jump.
// The chosen address is word-aligned by clearing bits [1:0].
module pc_redirect_mux
    import pc_seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic              exc_req,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              redirect,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] sel_addr;

    always_comb begin
        sel_addr = jump_target;
        if (exc_req)
            sel_addr = EXC_VECTOR;
        else if (branch_taken)
            sel_addr = branch_target;
    end

    assign redirect = exc_req | branch_taken | jump;
    assign target   = sel_addr & ~ADDR_W'(3);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer: owns the single PC register and handshakes with imem,
// never abandoning an outstanding request when a redirect arrives.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);

    seq_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] pend_target_reg, pend_target_next;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target;
    logic              redirect;
    logic              imem_req;
    logic              if_valid;
    logic              flush;

    pc_redirect_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_redirect_mux (
        .exc_req       (bus.exc_req),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .jump          (bus.jump),
        .jump_target   (bus.jump_target),
        .redirect      (redirect),
        .target        (target)
    );

    assign pc_plus4 = pc_reg + ADDR_W'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_VECTOR;
            pend_target_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            pend_target_reg <= pend_target_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        pend_target_next = pend_target_reg;
        imem_req         = 1'b0;
        if_valid         = 1'b0;
        flush            = 1'b0;
        unique case (state_reg)
            BOOT: state_next = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    flush = 1'b1;
                    if (bus.imem_ready) begin
                        pc_next = target;
                    end else begin
                        pend_target_next = target;
                        state_next       = DRAIN;
                    end
                end else if (bus.imem_ready) begin
                    if (!bus.stall) begin
                        if_valid = 1'b1;
                        pc_next  = pc_plus4;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            DRAIN: begin
                // The in-flight fetch must finish; its data is discarded on completion.
                imem_req = 1'b1;
                if (redirect) begin
                    flush            = 1'b1;
                    pend_target_next = target;
                end
                if (bus.imem_ready) begin
                    pc_next    = redirect ? target : pend_target_reg;
                    state_next = REQ;
                end
            end
            HOLD: begin
                if (redirect) begin
                    flush      = 1'b1;
                    pc_next    = target;
                    state_next = REQ;
                end else if (!bus.stall) begin
                    state_next = REQ;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    assign bus.imem_req = imem_req;
    assign bus.pc       = pc_reg;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.if_valid = if_valid;
    assign bus.flush    = flush;

endmodule
